// File: rtl/ped_request_ctrl.sv
// Pedestrian request front end: synchronises and debounces an active-low button,
// qualifies presses against the lamp phase and holds one request until acknowledged.
module ped_request_ctrl #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd240_000,
    parameter logic [31:0] HOLDOFF_CYCLES  = 32'd48_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic [2:0] phase_in,
    input  logic       req_ack,
    output logic       req_pending,
    output logic       wait_led_n,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic [2:0] PHASE_RED = 3'b011;

    state_t      state;
    state_t      state_next;
    logic        sync1;
    logic        sync2;
    logic        stable;
    logic        press_evt;
    logic [31:0] deb_cnt;
    logic [31:0] hold_cnt;
    logic [31:0] hold_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // A new level is accepted only after it has held for a full debounce window;
    // the accepting edge also emits the one-cycle press pulse on a falling level.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable    <= 1'b1;
            deb_cnt   <= '0;
            press_evt <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (sync2 == stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt >= DEBOUNCE_CYCLES) begin
                stable    <= sync2;
                deb_cnt   <= '0;
                press_evt <= ~sync2;
            end else begin
                deb_cnt <= deb_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        case (state)
            IDLE: begin
                if (press_evt && (phase_in != PHASE_RED)) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (req_ack) begin
                    state_next    = HOLDOFF;
                    hold_cnt_next = '0;
                end
            end
            HOLDOFF: begin
                if (hold_cnt >= (HOLDOFF_CYCLES - 32'd1)) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + 32'd1;
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    // Outputs are flops that track the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pending <= 1'b0;
            wait_led_n  <= 1'b1;
            press_count <= 8'h00;
        end else begin
            req_pending <= (state_next == PENDING);
            wait_led_n  <= (state_next != PENDING);
            if (press_evt && (press_count != 8'hFF)) begin
                press_count <= press_count + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Randomised and directed bench for ped_request_ctrl with a scoreboard fed by a
// history-based reference model.
module tb_ped_request_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic       clk;
    logic       rst;
    logic       btn_n;
    logic [2:0] phase_in;
    logic       req_ack;
    logic       req_pending;
    logic       wait_led_n;
    logic [7:0] press_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       pend;
        logic       led;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    ped_request_ctrl #(
        .DEBOUNCE_CYCLES(32'(DEB)),
        .HOLDOFF_CYCLES (32'(HOLD))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .phase_in   (phase_in),
        .req_ack    (req_ack),
        .req_pending(req_pending),
        .wait_led_n (wait_led_n),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic [2:0] ph, input logic a,
                                 input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_n    = b;
            phase_in = ph;
            req_ack  = a;
            rst      = r;
        end
    endtask

    // Reference model: a level is accepted once the last DEB+1 debouncer samples
    // all differ from it; the button reaches the debouncer two edges late.
    int   k      = 0;
    int   m_cnt  = 0;
    int   m_st   = 0;
    int   ho_end = 0;
    logic m_stable = 1'b1;
    logic ev_pend  = 1'b0;
    logic eff_d1   = 1'b1;
    logic eff_d2   = 1'b1;
    logic rst_d1   = 1'b1;
    logic win[$];

    always @(posedge clk) begin
        logic sample;
        logic accept;
        sample = rst_d1 ? 1'b1 : eff_d2;
        k++;
        if (rst) begin
            m_st     = 0;
            m_cnt    = 0;
            m_stable = 1'b1;
            ev_pend  = 1'b0;
            win.delete();
        end else begin
            if (ev_pend && m_cnt < 255) m_cnt++;
            case (m_st)
                0: if (ev_pend && phase_in != 3'b011) m_st = 1;
                1: if (req_ack) begin
                       m_st   = 2;
                       ho_end = k + HOLD;
                   end
                default: if (k == ho_end) m_st = 0;
            endcase
            win.push_back(sample);
            if (win.size() > DEB + 1) void'(win.pop_front());
            accept = (win.size() == DEB + 1);
            foreach (win[i]) if (win[i] == m_stable) accept = 1'b0;
            ev_pend = accept && m_stable;
            if (accept) begin
                m_stable = ~m_stable;
                win.delete();
            end
        end
        eff_d2 = eff_d1;
        eff_d1 = rst ? 1'b1 : btn_n;
        rst_d1 = rst;
        exp_q.push_back('{pend: (m_st == 1), led: (m_st != 1), cnt: 8'(m_cnt)});
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("req_pending", int'(req_pending), int'(e.pend));
            checkOutput("wait_led_n", int'(wait_led_n), int'(e.led));
            checkOutput("press_count", int'(press_count), int'(e.cnt));
        end
    end

    int lat;
    int lo;
    int hi;
    logic [2:0] ph;

    initial begin
        btn_n    = 1'b1;
        phase_in = 3'b110;
        req_ack  = 1'b0;
        rst      = 1'b1;

        applyStimulus(1'b1, 3'b110, 1'b0, 1'b1, 3);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 100);
        checkOutput("idle_pending", int'(req_pending), 0);
        checkOutput("idle_led", int'(wait_led_n), 1);
        checkOutput("idle_count", int'(press_count), 0);

        // Clean press in green: measure edges from first low sample to req_pending.
        applyStimulus(1'b0, 3'b110, 1'b0, 1'b0, 1);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (req_pending && lat < 0) lat = i - 1;
        end
        checkOutput("press_latency", lat, 7);
        checkOutput("press_led", int'(wait_led_n), 0);
        checkOutput("press_count1", int'(press_count), 1);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 20);
        checkOutput("no_timeout", int'(req_pending), 1);
        applyStimulus(1'b1, 3'b110, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 15);

        $display("[TB] bounce rejection");
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b1, 2);
        for (int i = 0; i < 15; i++) applyStimulus(i[0], 3'b110, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 20);
        checkOutput("bounce_count", int'(press_count), 0);

        $display("[TB] red phase drop");
        applyStimulus(1'b0, 3'b011, 1'b0, 1'b0, 12);
        applyStimulus(1'b1, 3'b011, 1'b0, 1'b0, 12);
        checkOutput("red_pending", int'(req_pending), 0);
        checkOutput("red_count", int'(press_count), 1);

        $display("[TB] handshake and hold-off");
        applyStimulus(1'b0, 3'b110, 1'b0, 1'b0, 10);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 6);
        applyStimulus(1'b1, 3'b110, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 3'b110, 1'b0, 1'b0, 8);
        checkOutput("holdoff_ignore", int'(req_pending), 0);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 8);
        applyStimulus(1'b0, 3'b101, 1'b0, 1'b0, 10);
        checkOutput("holdoff_repress", int'(req_pending), 1);
        applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 10);

        $display("[TB] simultaneous ack and press");
        applyStimulus(1'b0, 3'b110, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 3'b110, 1'b0, 1'b0, DEB + 2);
        applyStimulus(1'b0, 3'b110, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 3'b110, 1'b0, 1'b0, 1);
        checkOutput("ack_wins", int'(req_pending), 0);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 20);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 3'b110, 1'b0, 1'b0, 10);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 1);
        checkOutput("reset_pending", int'(req_pending), 0);
        checkOutput("reset_count", int'(press_count), 0);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 10);

        $display("[TB] randomised traffic");
        for (int it = 0; it < 80; it++) begin
            ph = 3'($urandom_range(0, 7));
            lo = int'($urandom_range(1, 12));
            hi = int'($urandom_range(1, 12));
            for (int c = 0; c < lo + hi; c++) begin
                applyStimulus((c < lo) ? 1'b0 : 1'b1, ph, ($urandom_range(0, 4) == 0),
                              ($urandom_range(0, 60) == 0), 1);
            end
        end

        $display("[TB] saturation");
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b1, 2);
        for (int p = 0; p < 260; p++) begin
            applyStimulus(1'b0, 3'b110, 1'b0, 1'b0, 8);
            applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 8);
            applyStimulus(1'b1, 3'b110, 1'b1, 1'b0, 1);
            applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 11);
        end
        checkOutput("sat_count", int'(press_count), 255);

        @(negedge clk);
        #1;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
